// File: rtl/cache_mem_pkg.sv
// Shared types and derived-constant helpers for the cache main-memory port arbiter.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WB_BURST   = 2'd1,
    FILL_ISSUE = 2'd2,
    FILL_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_WB   = 1'b0,
    REQ_FILL = 1'b1
  } req_id_e;

  // Number of memory beats needed to move one cache block.
  function automatic int beats(input int block_size, input int data_width);
    return (block_size * 8) / data_width;
  endfunction

  // Counter width able to index every beat; never narrower than one bit.
  function automatic int cnt_width(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Beat index counter with synchronous clear, increment and a last-beat flag.
// Wraps back to zero after the final beat so it is ready for the next burst.
module mem_beat_counter
  import cache_mem_pkg::*;
#(
  parameter int BEATS = 8,
  parameter int CW    = cnt_width(BEATS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(BEATS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over increment; wrap to zero after the last beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (inc) begin
      if (cnt_q == LAST_VAL) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between the writeback and refill paths.
// Writeback always wins so a victim leaves before its replacement arrives;
// each grant is split into beats with generated addresses and done pulses.
module mem_port_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_req,
  input  logic [ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_wdata,
  output logic                     wb_beat_ack,
  output logic                     wb_done,
  input  logic                     fill_req,
  input  logic [ADDRESS_WIDTH-1:0] fill_addr,
  output logic                     fill_rvalid,
  output logic [DATA_WIDTH-1:0]    fill_rdata,
  output logic                     fill_done,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     busy,
  output logic                     err_rvalid
);

  localparam int BEATS    = beats(BLOCK_SIZE, DATA_WIDTH);
  localparam int CW       = cnt_width(BEATS);
  localparam int OFF_BITS = $clog2(BLOCK_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK   = ADDRESS_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [ADDRESS_WIDTH-1:0] BEAT_BYTES = ADDRESS_WIDTH'(DATA_WIDTH / 8);

  // Force the in-block offset to zero so beat addresses never carry out of the block.
  function automatic logic [ADDRESS_WIDTH-1:0] align_block(input logic [ADDRESS_WIDTH-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  arb_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic                     err_rvalid_q, err_rvalid_d;

  req_id_e                  grant_s;
  logic                     cnt_clr_s;
  logic                     issue_inc_s;
  logic                     resp_inc_s;
  logic [CW-1:0]            issue_cnt_s;
  logic [CW-1:0]            resp_cnt_s;
  logic                     issue_last_s;
  logic                     resp_last_s;
  logic                     in_fill_s;
  logic [ADDRESS_WIDTH-1:0] beat_addr_s;

  mem_beat_counter #(.BEATS(BEATS), .CW(CW)) u_issue_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .inc   (issue_inc_s),
    .cnt   (issue_cnt_s),
    .last  (issue_last_s)
  );

  mem_beat_counter #(.BEATS(BEATS), .CW(CW)) u_resp_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .inc   (resp_inc_s),
    .cnt   (resp_cnt_s),
    .last  (resp_last_s)
  );

  assign in_fill_s   = (state_q == FILL_ISSUE) || (state_q == FILL_DRAIN);
  assign beat_addr_s = base_q + (ADDRESS_WIDTH'(issue_cnt_s) * BEAT_BYTES);
  assign busy        = (state_q != IDLE);
  assign err_rvalid  = err_rvalid_q;

  // Next-state, grant and per-beat outputs; refill data is resolved first
  // because the issue phase may end on the same cycle as the final response.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    err_rvalid_d = err_rvalid_q;
    grant_s      = REQ_WB;
    cnt_clr_s    = 1'b0;
    issue_inc_s  = 1'b0;
    resp_inc_s   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {ADDRESS_WIDTH{1'b0}};
    mem_wdata    = {DATA_WIDTH{1'b0}};
    wb_beat_ack  = 1'b0;
    wb_done      = 1'b0;
    fill_rvalid  = 1'b0;
    fill_rdata   = {DATA_WIDTH{1'b0}};
    fill_done    = 1'b0;

    if (in_fill_s && mem_rvalid) begin
      fill_rvalid = 1'b1;
      fill_rdata  = mem_rdata;
      fill_done   = resp_last_s;
      resp_inc_s  = 1'b1;
    end else begin
      fill_rvalid = 1'b0;
    end

    case (state_q)
      IDLE: begin
        err_rvalid_d = err_rvalid_q | mem_rvalid;
        grant_s      = wb_req ? REQ_WB : REQ_FILL;
        if (wb_req || fill_req) begin
          cnt_clr_s = 1'b1;
          base_d    = align_block((grant_s == REQ_WB) ? wb_addr : fill_addr);
          state_d   = (grant_s == REQ_WB) ? WB_BURST : FILL_ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      WB_BURST: begin
        err_rvalid_d = err_rvalid_q | mem_rvalid;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = beat_addr_s;
        mem_wdata    = wb_wdata;
        if (mem_ready) begin
          wb_beat_ack = 1'b1;
          issue_inc_s = 1'b1;
          wb_done     = issue_last_s;
          state_d     = issue_last_s ? IDLE : WB_BURST;
        end else begin
          state_d = WB_BURST;
        end
      end
      FILL_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = beat_addr_s;
        if (mem_ready) begin
          issue_inc_s = 1'b1;
          if (issue_last_s) begin
            state_d = fill_done ? IDLE : FILL_DRAIN;
          end else begin
            state_d = FILL_ISSUE;
          end
        end else begin
          state_d = FILL_ISSUE;
        end
      end
      FILL_DRAIN: begin
        if (fill_done) begin
          state_d = IDLE;
        end else begin
          state_d = FILL_DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, block base and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= {ADDRESS_WIDTH{1'b0}};
      err_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      err_rvalid_q <= err_rvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default 32/32/32, 8 beats).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_beat_ack;
  logic        wb_done;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic        fill_rvalid;
  logic [31:0] fill_rdata;
  logic        fill_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err_rvalid;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_req      (wb_req),
    .wb_addr     (wb_addr),
    .wb_wdata    (wb_wdata),
    .wb_beat_ack (wb_beat_ack),
    .wb_done     (wb_done),
    .fill_req    (fill_req),
    .fill_addr   (fill_addr),
    .fill_rvalid (fill_rvalid),
    .fill_rdata  (fill_rdata),
    .fill_done   (fill_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .err_rvalid  (err_rvalid)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Memory read-latency model: a read accepted in cycle t returns in cycle t+4.
  bit       lat_on;
  bit [3:0] lat;
  int       rd_idx;

  // Burst statistics gathered by run().
  int          wb_beats, n_acc, n_rv, wb_done_cyc, first_rd_cyc, fill_done_cyc, drain_cyc;
  logic [31:0] wb_base, fill_base;

  int beat;
  bit rdy;
  bit last_ack;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; called at the falling edge so the read accept is sampled stably.
  task automatic cyc();
    logic acc;
    acc = mem_req & mem_ready & ~mem_we;
    @(posedge clk);
    #1;
    if (lat_on) begin
      lat        = {lat[2:0], acc};
      mem_rvalid = lat[3];
      if (lat[3]) begin
        mem_rdata = 32'hD000_0000 + 32'(rd_idx);
        rd_idx++;
      end else begin
        mem_rdata = 32'h0;
      end
    end
  endtask

  // Run bursts to completion with mem_ready high; requesters drop on their done pulse.
  task automatic run(input int max_cyc);
    bit   fin;
    logic ack_seen, wbd, fd;
    wb_beats = 0; n_acc = 0; n_rv = 0; drain_cyc = 0;
    wb_done_cyc = -1; first_rd_cyc = -1; fill_done_cyc = -1;
    fin = 1'b0;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      @(negedge clk);
      if (!wb_req && !fill_req && !busy) begin
        fin = 1'b1;
      end else begin
        if (mem_req && mem_ready && mem_we) begin
          check_eq("wb_beat_addr", mem_addr, wb_base + 32'(4 * wb_beats));
          check_eq("wb_beat_data", mem_wdata, 32'h0000_00A0 + 32'(wb_beats));
          wb_beats++;
        end
        if (mem_req && mem_ready && !mem_we) begin
          if (n_acc == 0) first_rd_cyc = c;
          check_eq("rd_beat_addr", mem_addr, fill_base + 32'(4 * n_acc));
          n_acc++;
        end
        if (busy && !mem_req) drain_cyc++;
        if (fill_rvalid) begin
          check_eq("fill_rdata", fill_rdata, 32'hD000_0000 + 32'(n_rv));
          n_rv++;
        end
        if (wb_done) wb_done_cyc = c;
        if (fill_done) fill_done_cyc = c;
        ack_seen = wb_beat_ack;
        wbd      = wb_done;
        fd       = fill_done;
        cyc();
        if (ack_seen) wb_wdata = wb_wdata + 32'h1;
        if (wbd) wb_req = 1'b0;
        if (fd) fill_req = 1'b0;
      end
    end
    check_eq("run_completed", fin, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_req"}, mem_req, 1'b0);
    check_eq({tag, "_mem_we"}, mem_we, 1'b0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'h0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check_eq({tag, "_wb_ack"}, wb_beat_ack, 1'b0);
    check_eq({tag, "_wb_done"}, wb_done, 1'b0);
    check_eq({tag, "_fill_rvalid"}, fill_rvalid, 1'b0);
    check_eq({tag, "_fill_rdata"}, fill_rdata, 32'h0);
    check_eq({tag, "_fill_done"}, fill_done, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_err"}, err_rvalid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    wb_req = 1'b0; wb_addr = 32'h0; wb_wdata = 32'h0;
    fill_req = 1'b0; fill_addr = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    lat_on = 1'b0; lat = 4'h0; rd_idx = 0;
    wb_base = 32'h0; fill_base = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_rst");

    // Writeback burst, mem_ready tied high: 8 consecutive beats
    cyc();
    wb_req = 1'b1; wb_addr = 32'h1000_001C; wb_wdata = 32'hA0; mem_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_idle_no_req", mem_req, 1'b0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("t1_mem_we", mem_we, 1'b1);
      check_eq("t1_addr", mem_addr, 32'h1000_0000 + 32'(4 * i));
      check_eq("t1_wdata", mem_wdata, 32'hA0 + 32'(i));
      check_eq("t1_ack", wb_beat_ack, 1'b1);
      check_eq("t1_done", wb_done, (i == 7));
      cyc();
      wb_wdata = wb_wdata + 32'h1;
      if (i == 7) wb_req = 1'b0;
    end
    @(negedge clk);
    check_eq("t1_back_idle", busy, 1'b0);

    // Simultaneous requests: writeback first, refill one IDLE cycle after wb_done
    cyc();
    wb_req = 1'b1; wb_addr = 32'h2000_0040; wb_base = 32'h2000_0040; wb_wdata = 32'hA0;
    fill_req = 1'b1; fill_addr = 32'h3000_0004; fill_base = 32'h3000_0000;
    lat_on = 1'b1; lat = 4'h0; rd_idx = 0;
    run(60);
    check_eq("t2_wb_beats", wb_beats, 8);
    check_eq("t2_wb_done_cyc", wb_done_cyc, 8);
    check_eq("t2_first_rd_cyc", first_rd_cyc, 10);
    check_eq("t2_rd_accepts", n_acc, 8);
    check_eq("t2_rvalids", n_rv, 8);
    check_eq("t2_fill_done_cyc", fill_done_cyc, 21);

    // Backpressure: 3 stall cycles on beat 2 of a writeback
    cyc();
    lat_on = 1'b0; mem_rvalid = 1'b0;
    wb_req = 1'b1; wb_addr = 32'h0000_2008; wb_wdata = 32'hB0; mem_ready = 1'b1;
    last_ack = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (last_ack) wb_wdata = wb_wdata + 32'h1;
      if (c == 12) wb_req = 1'b0;
      rdy = !(c >= 3 && c <= 5);
      mem_ready = rdy;
      @(negedge clk);
      if (c == 12) begin
        check_eq("t3_idle_after_11", busy, 1'b0);
      end else begin
        beat = (c < 3) ? c - 1 : ((c <= 5) ? 2 : c - 4);
        check_eq("t3_req", mem_req, 1'b1);
        check_eq("t3_addr", mem_addr, 32'h0000_2000 + 32'(4 * beat));
        check_eq("t3_wdata", mem_wdata, 32'hB0 + 32'(beat));
        check_eq("t3_ack", wb_beat_ack, rdy);
        check_eq("t3_done", wb_done, (c == 11));
        last_ack = rdy;
      end
    end
    mem_ready = 1'b1;

    // Refill with 4-cycle read latency; FILL_DRAIN covers the last 4 responses
    cyc();
    fill_req = 1'b1; fill_addr = 32'h0000_0104; fill_base = 32'h0000_0100;
    lat_on = 1'b1; lat = 4'h0; rd_idx = 0;
    run(40);
    check_eq("t4_first_rd_cyc", first_rd_cyc, 1);
    check_eq("t4_rd_accepts", n_acc, 8);
    check_eq("t4_rvalids", n_rv, 8);
    check_eq("t4_fill_done_cyc", fill_done_cyc, 12);
    check_eq("t4_drain_cycles", drain_cyc, 4);
    check_eq("t4_no_wb", wb_beats, 0);

    // Zero-latency refill: last response with last issue goes straight to IDLE
    cyc();
    lat_on = 1'b0; mem_rvalid = 1'b0;
    fill_req = 1'b1; fill_addr = 32'h0000_0040;
    @(negedge clk);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hE0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("t5_addr", mem_addr, 32'h0000_0040 + 32'(4 * k));
      check_eq("t5_rvalid", fill_rvalid, 1'b1);
      check_eq("t5_rdata", fill_rdata, 32'hE0 + 32'(k));
      check_eq("t5_done", fill_done, (k == 7));
      cyc();
      mem_rdata = 32'hE0 + 32'(k + 1);
      if (k == 7) begin
        fill_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      end
    end
    @(negedge clk);
    check_eq("t5_direct_idle", busy, 1'b0);

    // Reset in the middle of a refill, then a fresh writeback
    cyc();
    fill_req = 1'b1; fill_addr = 32'h0000_0200; fill_base = 32'h0000_0200;
    lat_on = 1'b1; lat = 4'h0; rd_idx = 0;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      @(negedge clk);
    end
    check_eq("t6_mid_burst", mem_req, 1'b1);
    cyc();
    reset = 1'b1;
    #1;
    check_all_zero("t6_in_rst");
    lat_on = 1'b0; lat = 4'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0; fill_req = 1'b0;
    @(negedge clk);
    check_all_zero("t6_rst_hold");
    cyc();
    reset = 1'b0;
    wb_req = 1'b1; wb_addr = 32'h0000_4010; wb_base = 32'h0000_4000; wb_wdata = 32'hA0;
    run(30);
    check_eq("t6_wb_beats", wb_beats, 8);
    check_eq("t6_wb_done_cyc", wb_done_cyc, 8);
    check_eq("t6_no_fill", n_rv, 0);

    // Spurious read data in IDLE sets the sticky error, never reaches fill_rdata
    check_eq("t7_err_clear", err_rvalid, 1'b0);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_DEAD;
    @(negedge clk);
    check_eq("t7_no_fill_rvalid", fill_rvalid, 1'b0);
    check_eq("t7_no_fill_rdata", fill_rdata, 32'h0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check_eq("t7_err_set", err_rvalid, 1'b1);
    repeat (3) cyc();
    @(negedge clk);
    check_eq("t7_err_sticky", err_rvalid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single main-memory port between the cache's two block-transfer requesters: the dirty-victim writeback path and the miss refill path. It grants one requester at a time with fixed writeback-first priority, so a victim always leaves before its replacement arrives. It then splits the block into `DATA_WIDTH` beats, generates beat addresses, and reports per-beat and end-of-burst events. It sits between the cache flow-control FSM and the main-memory interface.

## Interface
- `ADDRESS_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, memory beat width in bits.
- `BLOCK_SIZE`, 32, cache block size in bytes. Legal only if `BLOCK_SIZE*8` is a multiple of `DATA_WIDTH`. `BEATS = BLOCK_SIZE*8/DATA_WIDTH` (8 at defaults).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wb_req` in 1: writeback request; held until `wb_done`.
- `wb_addr` in `ADDRESS_WIDTH`: victim block address. Offset bits are ignored.
- `wb_wdata` in `DATA_WIDTH`: current writeback beat; advanced by the requester after each `wb_beat_ack`.
- `wb_beat_ack` out 1: current `wb_wdata` beat accepted by memory.
- `wb_done` out 1: final writeback beat accepted.
- `fill_req` in 1: refill request; held until `fill_done`.
- `fill_addr` in `ADDRESS_WIDTH`: missed block address. Offset bits are ignored.
- `fill_rvalid` out 1: `fill_rdata` is valid.
- `fill_rdata` out `DATA_WIDTH`: refill beat data.
- `fill_done` out 1: final refill beat delivered.
- `mem_req` out 1: beat command valid.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out `ADDRESS_WIDTH`: beat byte address.
- `mem_wdata` out `DATA_WIDTH`: write beat data.
- `mem_ready` in 1: memory accepts the command this cycle.
- `mem_rvalid` in 1: read beat returned, in order.
- `mem_rdata` in `DATA_WIDTH`: read beat data.
- `busy` out 1: state is not IDLE.
- `err_rvalid` out 1: sticky flag, set by `mem_rvalid` outside a refill.

## Operation
- **FSM states**: IDLE, WB_BURST, FILL_ISSUE, FILL_DRAIN.
- **IDLE**
  - If `wb_req` is high: latch the block-aligned `wb_addr` (offset bits forced to 0) into `base`, clear the counters, and go to WB_BURST.
  - Otherwise, if `fill_req` is high: latch the aligned `fill_addr` and go to FILL_ISSUE.
  - If both are high, writeback wins.
- **Beat address**: `mem_addr = base + issue_cnt*(DATA_WIDTH/8)`, modulo 2^`ADDRESS_WIDTH`. There is no carry into bits above the block, because `base` is aligned.
- **WB_BURST**
  - `mem_req=1`, `mem_we=1`, `mem_wdata=wb_wdata`.
  - Each cycle with `mem_ready` high: `wb_beat_ack=1`, `issue_cnt++`.
  - On the accept with `issue_cnt==BEATS-1`: `wb_done=1` and go to IDLE.
- **FILL_ISSUE**
  - `mem_req=1`, `mem_we=0`. `issue_cnt++` on each `mem_ready`.
  - After the `BEATS`-th accept, go to FILL_DRAIN. If the final response arrives in that same cycle, go directly to IDLE instead.
- **Refill data** (FILL_ISSUE or FILL_DRAIN)
  - `fill_rvalid = mem_rvalid`, `fill_rdata = mem_rdata`, `resp_cnt++` per beat.
  - `fill_done=1` on the beat with `resp_cnt==BEATS-1`, then go to IDLE.
  - Issue and response counts may update in the same cycle.
- **Requests are not cancellable**: dropping `wb_req` or `fill_req` mid-burst is ignored and the burst completes.
- **Unexpected data**: `mem_rvalid` in IDLE or WB_BURST sets `err_rvalid`. It is never passed to `fill_rdata`.
- **Reset**
  - State = IDLE; `base`, `issue_cnt`, `resp_cnt` = 0; `err_rvalid` = 0.
  - All outputs read 0 during and after reset.
  - Reset mid-burst abandons the burst without asserting `wb_done` or `fill_done`.

## Timing
- State, `base`, counters and `err_rvalid` are registered.
- All other outputs are combinational from state, counters and inputs:
  - `mem_req` and `mem_we` depend only on state.
  - `wb_beat_ack`, `wb_done`, `fill_rvalid` and `fill_done` also depend on `mem_ready` / `mem_rvalid`.
- Request to first `mem_req`: 1 cycle (grant is taken at the IDLE edge).
- `mem_addr` and `mem_wdata` must be stable while `mem_req` is high and `mem_ready` is low.
- `wb_done` and `fill_done` are single-cycle pulses, coincident with the final handshake.
  - The requester drops its request on that edge, so the next IDLE cycle sees the updated requests.
  - Minimum gap between bursts is one IDLE cycle.
- Writeback burst with `mem_ready` tied high: `BEATS` cycles.

## Structure
- Package `cache_mem_pkg`:
  - `arb_state_e` enum (IDLE, WB_BURST, FILL_ISSUE, FILL_DRAIN).
  - `req_id_e` enum (REQ_WB, REQ_FILL).
  - `beats()` function for derived constants.
- Sub-module `mem_beat_counter`:
  - `$clog2(BEATS)`-bit counter with clear, increment and `last` output.
  - Instantiated twice: once for issue, once for response.

## Test plan
- **Writeback burst**: `wb_req`, `wb_addr=0x1000_001C`, `mem_ready` always high → `mem_addr` = 0x1000_0000, 0x…04 … 0x…1C on 8 consecutive cycles. `wb_done` asserts on the 8th.
- **Simultaneous requests**: `wb_req` and `fill_req` rise together → writeback burst first. Refill `mem_req` starts 1 cycle after `wb_done` plus 1 IDLE cycle. No overlap between the two bursts.
- **Backpressure**: `mem_ready` low for 3 cycles on beat 2 of a writeback → `mem_addr` and `mem_wdata` hold. No `wb_beat_ack` during the stall. Total burst length 11 cycles.
- **Refill with latency**: memory returns data 4 cycles after each accept → 8 `fill_rvalid` pulses with correct data. `fill_done` on the 8th. FILL_DRAIN is entered after the last issue.
- **Spurious data**: `mem_rvalid` pulsed in IDLE → `err_rvalid`=1 and stays 1. `fill_rvalid` stays 0.
- **Reset mid-burst**: `reset` at beat 5 of a refill → all outputs are 0 immediately. After reset, a new `wb_req` starts from beat 0.
